mask_point_streamer: RTL and testbench

//  Producer side of the centroid point interface. Scans a raster pixel stream and

---
 rtl/mask_point_streamer_if.sv | 28 ++
 rtl/mask_point_streamer.sv | 108 ++++++++++
 tb/tb_mask_point_streamer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mask_point_streamer_if.sv
// Pixel-in / point-out bundle for mask_point_streamer.
// master = the streamer itself, slave = the pixel source / point consumer side.
interface mask_point_streamer_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] pixel_in;
    logic             pixel_valid_in;
    logic             sof_in;
    logic             pixel_ready_out;
    logic [10:0]      x_out;
    logic [9:0]       y_out;
    logic             valid_out;
    logic             tabulate_out;
    logic [20:0]      point_count_out;
    logic             sync_err_out;

    modport master (
        input  pixel_in, pixel_valid_in, sof_in,
        output pixel_ready_out, x_out, y_out, valid_out,
               tabulate_out, point_count_out, sync_err_out
    );

    modport slave (
        output pixel_in, pixel_valid_in, sof_in,
        input  pixel_ready_out, x_out, y_out, valid_out,
               tabulate_out, point_count_out, sync_err_out
    );
endinterface

// File: rtl/mask_point_streamer.sv
// Raster scanner that emits (x,y) for every pixel brighter than threshold_in and
// pulses tabulate once per completed frame. Define ROI_EN to add a rectangular window.
//
// state  | meaning
// IDLE   | waiting for an accepted sof pixel; other pixels are dropped
// ACTIVE | inside a frame, counting coordinates
// FLUSH  | one cycle after the last pixel; publishes the frame hit count
module mask_point_streamer #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int PIX_W    = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    mask_point_streamer_if.master pts,
    input  logic [PIX_W-1:0]      threshold_in
`ifdef ROI_EN
    ,
    input  logic [10:0]           roi_x0_in,
    input  logic [10:0]           roi_x1_in,
    input  logic [9:0]            roi_y0_in,
    input  logic [9:0]            roi_y1_in
`endif
);
    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [10:0] x_cnt, px_x;
    logic [9:0]  y_cnt, px_y;
    logic [20:0] hit_cnt;
    logic        accept, start, take, in_roi, hit, at_eol, last;

    assign pts.pixel_ready_out = (state != FLUSH);

    always_comb begin
        state_nxt = state;
        accept    = pts.pixel_valid_in & pts.pixel_ready_out;
        start     = accept & pts.sof_in;
        take      = accept & ((state == ACTIVE) | pts.sof_in);
        px_x      = pts.sof_in ? 11'd0 : x_cnt;
        px_y      = pts.sof_in ? 10'd0 : y_cnt;
`ifdef ROI_EN
        in_roi    = (px_x >= roi_x0_in) && (px_x <= roi_x1_in) &&
                    (px_y >= roi_y0_in) && (px_y <= roi_y1_in);
`else
        in_roi    = 1'b1;
`endif
        hit       = take & (pts.pixel_in > threshold_in) & in_roi;
        at_eol    = (px_x == X_LAST);
        last      = at_eol & (px_y == Y_LAST);
        case (state)
            IDLE:    if (start) state_nxt = ACTIVE;
            ACTIVE:  if (take && last) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state                <= IDLE;
            x_cnt                <= '0;
            y_cnt                <= '0;
            hit_cnt              <= '0;
            pts.x_out            <= '0;
            pts.y_out            <= '0;
            pts.valid_out        <= 1'b0;
            pts.tabulate_out     <= 1'b0;
            pts.point_count_out  <= '0;
            pts.sync_err_out     <= 1'b0;
        end else begin
            state            <= state_nxt;
            pts.valid_out    <= hit;
            pts.tabulate_out <= (state == FLUSH);
            pts.sync_err_out <= (state == ACTIVE) & start;

            if (take) begin
                if (last) begin
                    x_cnt <= '0;
                    y_cnt <= '0;
                end else if (at_eol) begin
                    x_cnt <= '0;
                    y_cnt <= px_y + 10'd1;
                end else begin
                    x_cnt <= px_x + 11'd1;
                    y_cnt <= px_y;
                end
            end

            // a restart discards the partial count of an aborted frame
            if (start)
                hit_cnt <= {20'd0, hit};
            else if (hit && (hit_cnt != '1))
                hit_cnt <= hit_cnt + 21'd1;

            if (hit) begin
                pts.x_out <= px_x;
                pts.y_out <= px_y;
            end

            if (state == FLUSH)
                pts.point_count_out <= hit_cnt;
        end
    end
endmodule

// File: tb/tb_mask_point_streamer.sv
// Directed bench for mask_point_streamer on an 8x4 frame; ROI cases need ROI_EN.
module tb_mask_point_streamer;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int PW = 8;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [PW-1:0] threshold_in;
`ifdef ROI_EN
    logic [10:0]   roi_x0, roi_x1;
    logic [9:0]    roi_y0, roi_y1;
`endif

    mask_point_streamer_if #(.PIX_W(PW)) pif ();

    mask_point_streamer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pts          (pif.master),
        .threshold_in (threshold_in)
`ifdef ROI_EN
        ,
        .roi_x0_in    (roi_x0),
        .roi_x1_in    (roi_x1),
        .roi_y0_in    (roi_y0),
        .roi_y1_in    (roi_y1)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // apply one cycle of input, then sample #1 after the edge
    task automatic drive(input logic v, input logic [PW-1:0] p, input logic s);
        pif.pixel_valid_in = v;
        pif.pixel_in       = p;
        pif.sof_in         = s;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int nhits;
        rst_in             = 1'b1;
        threshold_in       = 8'd100;
        pif.pixel_valid_in = 1'b0;
        pif.pixel_in       = '0;
        pif.sof_in         = 1'b0;
`ifdef ROI_EN
        roi_x0 = 11'd0; roi_x1 = 11'd2047; roi_y0 = 10'd0; roi_y1 = 10'd1023;
`endif
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_ready", pif.pixel_ready_out, 1);
        check("rst_valid", pif.valid_out, 0);
        check("rst_x", pif.x_out, 0);
        check("rst_y", pif.y_out, 0);
        check("rst_tab", pif.tabulate_out, 0);
        check("rst_count", pif.point_count_out, 0);
        check("rst_sync", pif.sync_err_out, 0);
        rst_in = 1'b0;

        // pixels before the first sof are dropped
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'd255, 1'b0);
            check("pre_sof_valid", pif.valid_out, 0);
        end

        // frame A: single bright pixel at (3,2)
        for (int i = 0; i < H * V; i++) begin
            drive(1'b1, (i == 19) ? 8'd200 : 8'd50, i == 0);
            check("a_valid", pif.valid_out, (i == 19) ? 1 : 0);
            check("a_tab_low", pif.tabulate_out, 0);
            if (i == 19) begin
                check("a_x", pif.x_out, 3);
                check("a_y", pif.y_out, 2);
            end
        end
        check("a_flush_ready", pif.pixel_ready_out, 0);
        check("a_flush_tab", pif.tabulate_out, 0);
        drive(1'b0, 8'd0, 1'b0);
        check("a_tab", pif.tabulate_out, 1);
        check("a_count", pif.point_count_out, 1);
        check("a_tab_valid", pif.valid_out, 0);
        drive(1'b0, 8'd0, 1'b0);
        check("a_tab_end", pif.tabulate_out, 0);
        check("a_hold_x", pif.x_out, 3);
        check("a_hold_y", pif.y_out, 2);
        check("a_count_hold", pif.point_count_out, 1);

        // frame B: every pixel equals the threshold, strict compare gives no hits
        nhits = 0;
        for (int i = 0; i < H * V; i++) begin
            drive(1'b1, 8'd100, i == 0);
            if (pif.valid_out === 1'b1) nhits++;
        end
        check("b_hits", nhits, 0);
        drive(1'b0, 8'd0, 1'b0);
        check("b_tab", pif.tabulate_out, 1);
        check("b_count", pif.point_count_out, 0);

        // frame C: all bright, random valid gaps (gap cycles carry a stray sof)
        drive(1'b0, 8'd0, 1'b0);
        for (int i = 0; i < H * V; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                drive(1'b0, 8'd255, 1'b1);
                check("c_gap_valid", pif.valid_out, 0);
            end
            drive(1'b1, 8'd255, i == 0);
            check("c_valid", pif.valid_out, 1);
            check("c_x", pif.x_out, i % H);
            check("c_y", pif.y_out, i / H);
        end
        check("c_flush_ready", pif.pixel_ready_out, 0);
        drive(1'b1, 8'd255, 1'b1);           // offered during FLUSH, must be ignored
        check("c_tab", pif.tabulate_out, 1);
        check("c_count", pif.point_count_out, 32);
        check("c_tab_valid", pif.valid_out, 0);
        check("c_ready_back", pif.pixel_ready_out, 1);

        // frame D: earliest new sof, then a mid-frame sof at (5,1)
        drive(1'b1, 8'd255, 1'b1);
        check("d_first_valid", pif.valid_out, 1);
        check("d_first_x", pif.x_out, 0);
        check("d_first_y", pif.y_out, 0);
        check("d_first_tab", pif.tabulate_out, 0);
        for (int i = 1; i < 13; i++) begin
            drive(1'b1, 8'd255, 1'b0);
            check("d1_valid", pif.valid_out, 1);
            check("d1_sync", pif.sync_err_out, 0);
            check("d1_tab", pif.tabulate_out, 0);
        end
        drive(1'b1, 8'd255, 1'b1);
        check("d_sync_err", pif.sync_err_out, 1);
        check("d_restart_valid", pif.valid_out, 1);
        check("d_restart_x", pif.x_out, 0);
        check("d_restart_y", pif.y_out, 0);
        for (int j = 1; j < H * V; j++) begin
            threshold_in = (j >= 24) ? 8'd255 : 8'd100;
            drive(1'b1, 8'd255, 1'b0);
            check("d2_valid", pif.valid_out, (j < 24) ? 1 : 0);
            check("d2_tab", pif.tabulate_out, 0);
            if (j == 1) check("d2_sync_end", pif.sync_err_out, 0);
            if (j == 23) begin
                check("d2_x", pif.x_out, 7);
                check("d2_y", pif.y_out, 2);
            end
        end
        drive(1'b0, 8'd0, 1'b0);
        check("d_tab", pif.tabulate_out, 1);
        check("d_count", pif.point_count_out, 24);

        // asynchronous reset mid-frame
        threshold_in = 8'd100;
        drive(1'b1, 8'd255, 1'b1);
        drive(1'b1, 8'd255, 1'b0);
        check("r_pre_valid", pif.valid_out, 1);
        check("r_pre_x", pif.x_out, 1);
        #3;
        rst_in = 1'b1;
        #1;
        check("r_valid", pif.valid_out, 0);
        check("r_x", pif.x_out, 0);
        check("r_count", pif.point_count_out, 0);
        check("r_ready", pif.pixel_ready_out, 1);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'd255, 1'b0);
            check("r_drop_valid", pif.valid_out, 0);
            check("r_no_tab", pif.tabulate_out, 0);
        end

`ifdef ROI_EN
        // window x 2..4, y 1..2
        roi_x0 = 11'd2; roi_x1 = 11'd4; roi_y0 = 10'd1; roi_y1 = 10'd2;
        nhits = 0;
        for (int i = 0; i < H * V; i++) begin
            drive(1'b1, 8'd255, i == 0);
            check("roi_valid", pif.valid_out,
                  ((i % H) >= 2 && (i % H) <= 4 && (i / H) >= 1 && (i / H) <= 2) ? 1 : 0);
            if (pif.valid_out === 1'b1) nhits++;
        end
        check("roi_hits", nhits, 6);
        drive(1'b0, 8'd0, 1'b0);
        check("roi_tab", pif.tabulate_out, 1);
        check("roi_count", pif.point_count_out, 6);

        // inverted window: no hits, still tabulates
        roi_x0 = 11'd5; roi_x1 = 11'd4;
        nhits = 0;
        drive(1'b0, 8'd0, 1'b0);
        for (int i = 0; i < H * V; i++) begin
            drive(1'b1, 8'd255, i == 0);
            if (pif.valid_out === 1'b1) nhits++;
        end
        check("roi_inv_hits", nhits, 0);
        drive(1'b0, 8'd0, 1'b0);
        check("roi_inv_tab", pif.tabulate_out, 1);
        check("roi_inv_count", pif.point_count_out, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
